// File: rtl/mul32_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mul32_arb                                                     |
// | Purpose  : Two-port round-robin arbiter in front of a fixed-latency      |
// |            pipelined 32x32 multiplier (mul32p). One operation is issued  |
// |            per cycle; a {valid,id} tag pipeline of depth LAT steers each |
// |            returning product to the requester that issued it.           |
// | Ports    : clk, rst (sync, active-low)                                   |
// |            req{0,1}_valid/_ready/_a/_b/_mode  requester handshake+operands|
// |            mul_a/mul_b/mul_mode                operands to mul32p         |
// |            mul_hi/mul_lo                       product from mul32p        |
// |            resp{0,1}_valid/_res                registered result pulses   |
// |            issue{0,1}_cnt                      accepted-op counters       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mul32_arb #(
  parameter int LAT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_mode,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_mode,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_mode,
  input  logic [31:0] mul_hi,
  input  logic [31:0] mul_lo,
  output logic        resp0_valid,
  output logic [63:0] resp0_res,
  output logic        resp1_valid,
  output logic [63:0] resp1_res,
  output logic [31:0] issue0_cnt,
  output logic [31:0] issue1_cnt
);

  // ptr = requester that wins when both are valid
  logic           ptr_q, ptr_d;
  logic [LAT-1:0] tag_vld_q, tag_vld_d;
  logic [LAT-1:0] tag_id_q, tag_id_d;
  logic           resp0_valid_q, resp0_valid_d;
  logic           resp1_valid_q, resp1_valid_d;
  logic [63:0]    resp0_res_q, resp0_res_d;
  logic [63:0]    resp1_res_q, resp1_res_d;
  logic [31:0]    cnt0_q, cnt0_d;
  logic [31:0]    cnt1_q, cnt1_d;

  logic w_gnt0, w_gnt1, w_acc;
  logic w_out_vld, w_out_id;

  // Grant is gated by rst so nothing is accepted (and mul inputs stay 0)
  // while reset is held.
  always_comb begin
    w_gnt0 = rst & req0_valid & (~req1_valid | ~ptr_q);
    w_gnt1 = rst & req1_valid & (~req0_valid |  ptr_q);
    w_acc  = w_gnt0 | w_gnt1;
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;

  always_comb begin
    mul_a    = 32'd0;
    mul_b    = 32'd0;
    mul_mode = 1'b0;
    if (w_gnt0) begin
      mul_a    = req0_a;
      mul_b    = req0_b;
      mul_mode = req0_mode;
    end else if (w_gnt1) begin
      mul_a    = req1_a;
      mul_b    = req1_b;
      mul_mode = req1_mode;
    end
  end

  // Tag pipeline: stage 0 holds the op issued last cycle, stage LAT-1 lines
  // up with the cycle in which mul32p presents that op's product.
  generate
    if (LAT > 1) begin : g_shift
      always_comb begin
        tag_vld_d = {tag_vld_q[LAT-2:0], w_acc};
        tag_id_d  = {tag_id_q[LAT-2:0],  w_gnt1};
      end
    end else begin : g_single
      always_comb begin
        tag_vld_d = w_acc;
        tag_id_d  = w_gnt1;
      end
    end
  endgenerate

  assign w_out_vld = tag_vld_q[LAT-1];
  assign w_out_id  = tag_id_q[LAT-1];

  always_comb begin
    ptr_d = ptr_q;
    if (w_gnt0) begin
      ptr_d = 1'b1;
    end else if (w_gnt1) begin
      ptr_d = 1'b0;
    end
    resp0_valid_d = w_out_vld & ~w_out_id;
    resp1_valid_d = w_out_vld &  w_out_id;
    resp0_res_d   = resp0_valid_d ? {mul_hi, mul_lo} : resp0_res_q;
    resp1_res_d   = resp1_valid_d ? {mul_hi, mul_lo} : resp1_res_q;
    cnt0_d        = cnt0_q + 32'(w_gnt0);
    cnt1_d        = cnt1_q + 32'(w_gnt1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q         <= 1'b0;
      tag_vld_q     <= '0;
      tag_id_q      <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
      resp0_res_q   <= 64'd0;
      resp1_res_q   <= 64'd0;
      cnt0_q        <= 32'd0;
      cnt1_q        <= 32'd0;
    end else begin
      ptr_q         <= ptr_d;
      tag_vld_q     <= tag_vld_d;
      tag_id_q      <= tag_id_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
      resp0_res_q   <= resp0_res_d;
      resp1_res_q   <= resp1_res_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
    end
  end

  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp0_res   = resp0_res_q;
  assign resp1_res   = resp1_res_q;
  assign issue0_cnt  = cnt0_q;
  assign issue1_cnt  = cnt1_q;

endmodule
`default_nettype wire
